// File: rtl/headbang_pkg.sv
// Shared constants and types for the head-motion beat path.
package headbang_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int BEAT_CNT_W = 8;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } bd_state_t;

endpackage

// File: rtl/beat_detector_envelope_follower.sv
// Leaky-integrator amplitude envelope: acc += mag - acc/2^SHIFT, env = acc/2^SHIFT.
module envelope_follower #(
    parameter int SAMPLE_W = 16,
    parameter int SHIFT    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-2:0] mag,
    output logic [SAMPLE_W-1:0] env
);

    localparam int ACC_W = SAMPLE_W + SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Steady state is mag*2^SHIFT < 2^(ACC_W-1), so the sum never wraps.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + ACC_W'(mag) - (acc_q >> SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign env = acc_q[ACC_W-1 -: SAMPLE_W];

endmodule

// File: rtl/beat_detector.sv
// Beat detector: rectifier, short/long envelope compare and refractory FSM
// producing a one-frame beat_pulse for the servo sequencer.
module beat_detector #(
    parameter int SAMPLE_W       = headbang_pkg::SAMPLE_W,
    parameter int SHORT_SHIFT    = 6,
    parameter int LONG_SHIFT     = 12,
    parameter int THRESH_Q2      = 6,
    parameter int MIN_LEVEL      = 512,
    parameter int HOLDOFF_FRAMES = 12000
) (
    input  logic                                DAC_LR_CLK,
    input  logic                                reset,
    input  logic [SAMPLE_W-1:0]                 sample_in,
    input  logic                                sample_valid,
    output logic                                beat_pulse,
    output logic [headbang_pkg::BEAT_CNT_W-1:0] beat_count,
    output logic [SAMPLE_W-1:0]                 envelope,
    output logic [1:0]                          state
);

    import headbang_pkg::*;

    localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 1);
    localparam int CMP_W  = SAMPLE_W + 4;

    logic [SAMPLE_W-2:0] sample_low;
    logic [SAMPLE_W-2:0] mag;
    logic [SAMPLE_W-1:0] env_s;
    logic [SAMPLE_W-1:0] env_l;
    logic [CMP_W-1:0]    lhs;
    logic [CMP_W-1:0]    rhs;
    logic                trig;

    bd_state_t             state_q, state_d;
    logic [LONG_SHIFT-1:0] warm_q, warm_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  pulse_q, pulse_d;
    logic [BEAT_CNT_W-1:0] count_q, count_d;

    assign sample_low = sample_in[SAMPLE_W-2:0];

    // Most-negative input has no positive twin, so it saturates to all ones.
    always_comb begin
        if (!sample_in[SAMPLE_W-1]) begin
            mag = sample_low;
        end else if (sample_low == '0) begin
            mag = '1;
        end else begin
            mag = ~sample_low + (SAMPLE_W-1)'(1);
        end
    end

    envelope_follower #(.SAMPLE_W(SAMPLE_W), .SHIFT(SHORT_SHIFT)) u_env_short (
        .clk   (DAC_LR_CLK),
        .reset (reset),
        .en    (sample_valid),
        .mag   (mag),
        .env   (env_s)
    );

    envelope_follower #(.SAMPLE_W(SAMPLE_W), .SHIFT(LONG_SHIFT)) u_env_long (
        .clk   (DAC_LR_CLK),
        .reset (reset),
        .en    (sample_valid),
        .mag   (mag),
        .env   (env_l)
    );

    assign lhs  = CMP_W'({env_s, 2'b00});
    assign rhs  = CMP_W'(env_l) * CMP_W'(THRESH_Q2);
    assign trig = (lhs > rhs) && (env_s > SAMPLE_W'(MIN_LEVEL));

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        hold_d  = hold_q;
        count_d = count_q;
        pulse_d = 1'b0;
        if (sample_valid) begin
            case (state_q)
                WARMUP: begin
                    warm_d = warm_q + LONG_SHIFT'(1);
                    if (warm_q == '1) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        state_d = HOLDOFF;
                        hold_d  = HOLD_W'(HOLDOFF_FRAMES - 1);
                        pulse_d = 1'b1;
                        count_d = count_q + BEAT_CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_d = ARMED;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: state_d = WARMUP;
            endcase
        end
    end

    always_ff @(posedge DAC_LR_CLK) begin
        if (!reset) begin
            state_q <= WARMUP;
            warm_q  <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign beat_pulse = pulse_q;
    assign beat_count = count_q;
    assign envelope   = env_s;
    assign state      = state_q;

endmodule
